vpu_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the 16-bit VPU ALU/register-file datapath. Fetches 32-bit IR words

---
 rtl/vpu_pkg.sv | 52 +++++
 rtl/vpu_seq_ctrl_mul_timer.sv | 30 +++
 rtl/vpu_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_vpu_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared opcode map, IR field layout and sequencer state encoding for the
// 16-bit VPU datapath.
package vpu_pkg;

  localparam logic [4:0] OP_MOVSGPR = 5'h00;
  localparam logic [4:0] OP_MOV     = 5'h01;
  localparam logic [4:0] OP_ADD     = 5'h02;
  localparam logic [4:0] OP_SUB     = 5'h03;
  localparam logic [4:0] OP_MUL     = 5'h04;
  localparam logic [4:0] OP_AND     = 5'h05;
  localparam logic [4:0] OP_OR      = 5'h06;
  localparam logic [4:0] OP_XOR     = 5'h07;
  localparam logic [4:0] OP_NOT     = 5'h08;
  localparam logic [4:0] OP_RAND    = 5'h09;
  localparam logic [4:0] OP_RXOR    = 5'h0A;
  localparam logic [4:0] OP_RNOT    = 5'h0B;
  localparam logic [4:0] HALT_OP_DEF = 5'b11111;

  // IR field ranges; the immediate overlaps rsrc2 for immediate-form ops.
  localparam int unsigned IR_OPER_HI = 31;
  localparam int unsigned IR_OPER_LO = 27;
  localparam int unsigned IR_RDST_HI = 26;
  localparam int unsigned IR_RDST_LO = 23;
  localparam int unsigned IR_RS1_HI  = 22;
  localparam int unsigned IR_RS1_LO  = 19;
  localparam int unsigned IR_RS2_HI  = 18;
  localparam int unsigned IR_RS2_LO  = 15;
  localparam int unsigned IR_IMM_HI  = 15;
  localparam int unsigned IR_IMM_LO  = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } seq_state_t;

  function automatic logic is_legal(input logic [4:0] op);
    return (op <= OP_RNOT);
  endfunction

  function automatic logic writes_flags(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

  function automatic logic [4:0] ir_oper(input logic [31:0] word);
    return word[IR_OPER_HI:IR_OPER_LO];
  endfunction

endpackage

// File: rtl/vpu_seq_ctrl_mul_timer.sv
// Countdown used to hold EXEC for the multi-cycle multiply: loads MUL_LAT-1,
// decrements while enabled and saturates at zero.
module vpu_mul_timer #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CNT_W = $clog2(MUL_LAT) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MUL_LAT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/vpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the VPU datapath.
// Every output is a flop; imem_valid only reaches outputs through state.
module vpu_seq_ctrl
  import vpu_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned MUL_LAT = 3,
  parameter logic [4:0]  HALT_OP = HALT_OP_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic            alu_start,
  input  logic            alu_done,
  output logic            gpr_we,
  output logic            sgpr_we,
  output logic            flag_we,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  seq_state_t state, state_nx;

  logic [4:0] op;
  logic       is_mul;
  logic       mul_zero;
  logic       ir_load;
  logic       halt_set;
  logic       ill_set;
  logic       req_nx;
  logic       start_nx;
  logic       gpr_nx;
  logic       sgpr_nx;
  logic       flag_nx;

  assign op        = ir_oper(ir);
  assign is_mul    = (op == OP_MUL);
  assign imem_addr = pc;

  vpu_mul_timer #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_nx),
    .dec   (state == EXEC),
    .zero  (mul_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ir_load  = 1'b0;
    halt_set = 1'b0;
    ill_set  = 1'b0;
    start_nx = 1'b0;
    gpr_nx   = 1'b0;
    sgpr_nx  = 1'b0;
    flag_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_nx = FETCH;
      end
      FETCH: begin
        // A returning word wins over run dropping in the same cycle.
        if (imem_valid) begin
          ir_load  = 1'b1;
          state_nx = DECODE;
        end else if (!run) begin
          state_nx = IDLE;
        end
      end
      DECODE: begin
        if (op == HALT_OP) begin
          halt_set = 1'b1;
          state_nx = HALT;
        end else if (!is_legal(op)) begin
          halt_set = 1'b1;
          ill_set  = 1'b1;
          state_nx = HALT;
        end else begin
          start_nx = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        if (!is_mul || (mul_zero && alu_done)) begin
          gpr_nx   = 1'b1;
          sgpr_nx  = is_mul;
          flag_nx  = writes_flags(op);
          state_nx = WB;
        end
      end
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
    req_nx = (state_nx == FETCH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= '0;
      ir        <= '0;
      imem_req  <= 1'b0;
      alu_start <= 1'b0;
      gpr_we    <= 1'b0;
      sgpr_we   <= 1'b0;
      flag_we   <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      imem_req  <= req_nx;
      alu_start <= start_nx;
      gpr_we    <= gpr_nx;
      sgpr_we   <= sgpr_nx;
      flag_we   <= flag_nx;
      if (ir_load) begin
        ir <= imem_rdata;
        pc <= pc + PC_W'(1);
      end
      if (halt_set) halted  <= 1'b1;
      if (ill_set)  illegal <= 1'b1;
    end
  end

  strobe_vs_req : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_req && (alu_start || gpr_we || sgpr_we || flag_we)));

endmodule

// File: tb/tb_vpu_seq_ctrl.sv
// Randomised bench for vpu_seq_ctrl: imem/ALU responders feed a scoreboard
// with the outcome each fetched instruction must produce.
module tb_vpu_seq_ctrl;
  import vpu_pkg::*;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned MUL_LAT = 3;
  localparam logic [4:0]  HALT_C  = 5'b11111;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            run;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;
  logic [31:0]     ir;
  logic            alu_start;
  logic            alu_done;
  logic            gpr_we;
  logic            sgpr_we;
  logic            flag_we;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic            illegal;

  vpu_seq_ctrl #(
    .PC_W    (PC_W),
    .MUL_LAT (MUL_LAT),
    .HALT_OP (HALT_C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .gpr_we     (gpr_we),
    .sgpr_we    (sgpr_we),
    .flag_we    (flag_we),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_halt;
    logic       gpr;
    logic       sgpr;
    logic       flag;
    logic       ill;
    logic [7:0] pc;
    int         cyc;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] word;
  } start_t;

  typedef struct {
    int op;
    int stall;
    int d;
  } step_t;

  exp_t   exp_q[$];
  start_t start_q[$];
  step_t  script[$];

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mpc;
  int  stall_left, run_off, deliv_cnt, ep_len;
  int  halt_pct, ill_pct, drop_pct;
  bit  chk_idle, mul_pending;
  int  mul_exec_start, mul_d, mul_exit;
  logic [4:0] cur_op;
  int  cur_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [4:0] pick_op();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < halt_pct) return HALT_C;
    if (r < halt_pct + ill_pct) return 5'($urandom_range(12, 30));
    return 5'($urandom_range(0, 11));
  endfunction

  // Expected outcome of one instruction, derived from its opcode and the
  // cycle in which its word was handed to the sequencer.
  task automatic deliver();
    logic [31:0] rnd;
    logic [31:0] word;
    exp_t e;
    int exit_idx;
    rnd  = $urandom();
    word = {cur_op, rnd[26:0]};
    chk("fetch_addr_at_valid", 32'(imem_addr), 32'(mpc));
    imem_valid = 1'b1;
    imem_rdata = word;
    e = '{is_halt: 1'b0, gpr: 1'b0, sgpr: 1'b0, flag: 1'b0, ill: 1'b0,
          pc: mpc + 8'd1, cyc: 0};
    if (cur_op == HALT_C) begin
      e.is_halt = 1'b1;
      e.cyc     = cyc + 2;
    end else if (cur_op >= 5'd12) begin
      e.is_halt = 1'b1;
      e.ill     = 1'b1;
      e.cyc     = cyc + 2;
    end else begin
      exit_idx = 0;
      if (cur_op == OP_MUL) begin
        exit_idx       = (cur_d > int'(MUL_LAT) - 1) ? cur_d : int'(MUL_LAT) - 1;
        mul_pending    = 1'b1;
        mul_exec_start = cyc + 2;
        mul_d          = cur_d;
        mul_exit       = exit_idx;
      end
      e.gpr  = 1'b1;
      e.sgpr = (cur_op == OP_MUL);
      e.flag = (cur_op == OP_ADD) || (cur_op == OP_SUB) || (cur_op == OP_MUL);
      e.cyc  = cyc + 3 + exit_idx;
      start_q.push_back('{cyc: cyc + 2, word: word});
    end
    exp_q.push_back(e);
    mpc        = mpc + 8'd1;
    deliv_cnt++;
    stall_left = -1;
  endtask

  task automatic drive_cycle();
    step_t st;
    if (mul_pending && cyc > mul_exec_start + mul_exit) mul_pending = 1'b0;
    if (mul_pending && cyc >= mul_exec_start)
      alu_done = (cyc - mul_exec_start >= mul_d);
    else
      alu_done = 1'($urandom_range(0, 1));

    if (chk_idle) begin
      chk("run_drop_req", 32'(imem_req), 0);
      chk("run_drop_pc", 32'(pc), 32'(mpc));
      chk_idle = 1'b0;
    end

    imem_valid = 1'b0;
    imem_rdata = $urandom();
    if (run_off > 0) begin
      run_off--;
      if (run_off == 0) run = 1'b1;
      imem_valid = 1'($urandom_range(0, 1));
    end else if (!imem_req) begin
      imem_valid = ($urandom_range(0, 3) == 0);
    end else begin
      chk("fetch_addr", 32'(imem_addr), 32'(mpc));
      chk("fetch_quiet", 32'({alu_start, gpr_we, sgpr_we, flag_we}), 0);
      if (deliv_cnt < ep_len) begin
        if (stall_left < 0) begin
          if (script.size() > 0) st = script.pop_front();
          else st = '{op: -1, stall: -1, d: -1};
          cur_op = (st.op >= 0) ? 5'(st.op) : pick_op();
          cur_d  = (st.d >= 0) ? st.d : int'($urandom_range(0, MUL_LAT + 3));
          if (st.stall >= 0) stall_left = st.stall;
          else stall_left = ($urandom_range(0, 99) < 60) ? 0 : int'($urandom_range(1, 4));
        end
        if (stall_left == 0) begin
          deliver();
        end else if (int'($urandom_range(0, 99)) < drop_pct) begin
          run      = 1'b0;
          run_off  = int'($urandom_range(1, 3));
          chk_idle = 1'b1;
        end else begin
          stall_left--;
        end
      end
    end
  endtask

  task automatic reset_and_check(input string tag);
    rst_n      = 1'b0;
    run        = 1'b0;
    imem_valid = 1'b0;
    alu_done   = 1'b0;
    @(negedge clk);
    chk({tag, "_pc"}, 32'(pc), 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_strobes"}, 32'({imem_req, alu_start, gpr_we, sgpr_we, flag_we}), 0);
    chk({tag, "_sticky"}, 32'({halted, illegal}), 0);
    exp_q.delete();
    start_q.delete();
    script.delete();
    mpc         = '0;
    mul_pending = 1'b0;
    stall_left  = -1;
    run_off     = 0;
    chk_idle    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_episode(input int len, input int hp, input int ip, input int dp,
                             input bit mid_rst);
    bit done;
    ep_len    = len;
    halt_pct  = hp;
    ill_pct   = ip;
    drop_pct  = dp;
    deliv_cnt = 0;
    run       = 1'b1;
    done      = 1'b0;
    for (int t = 0; t < 6000 && !done; t++) begin
      @(negedge clk);
      if (mid_rst && alu_start && mul_pending) begin
        reset_and_check("mid_mul_reset");
        done = 1'b1;
      end else begin
        drive_cycle();
        if ((halted || deliv_cnt >= ep_len) && exp_q.size() == 0 && start_q.size() == 0)
          done = 1'b1;
      end
    end
    if (!done) chk("episode_timeout", 1, 0);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      drive_cycle();
    end
    chk("leftover_expect", 32'(exp_q.size() + start_q.size()), 0);
    reset_and_check("reset");
  endtask

  // Scoreboard monitor: consumes an expectation whenever the DUT shows a
  // launch, a writeback or the halt.
  logic   prev_halted = 1'b0;
  exp_t   mon_e;
  start_t mon_s;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (alu_start) begin
        if (start_q.size() == 0) begin
          chk("alu_start_unexpected", 32'(alu_start), 0);
        end else begin
          mon_s = start_q.pop_front();
          chk("alu_start_cycle", 32'(cyc), 32'(mon_s.cyc));
          chk("ir_word", ir, mon_s.word);
        end
      end
      if (gpr_we || sgpr_we || flag_we) begin
        if (exp_q.size() == 0 || exp_q[0].is_halt) begin
          chk("wb_unexpected", 32'({gpr_we, sgpr_we, flag_we}), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_gpr_we", 32'(gpr_we), 32'(mon_e.gpr));
          chk("wb_sgpr_we", 32'(sgpr_we), 32'(mon_e.sgpr));
          chk("wb_flag_we", 32'(flag_we), 32'(mon_e.flag));
          chk("wb_pc", 32'(pc), 32'(mon_e.pc));
          chk("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("wb_req_excl", 32'(imem_req), 0);
        end
      end
      if (halted && !prev_halted) begin
        if (exp_q.size() == 0 || !exp_q[0].is_halt) begin
          chk("halt_unexpected", 32'(halted), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("halt_illegal", 32'(illegal), 32'(mon_e.ill));
          chk("halt_pc", 32'(pc), 32'(mon_e.pc));
          chk("halt_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      if (halted && prev_halted)
        chk("halt_quiet", 32'({imem_req, alu_start, gpr_we, sgpr_we, flag_we}), 0);
      prev_halted = halted;
    end else begin
      prev_halted = 1'b0;
    end
  end

  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    alu_done   = 1'b0;
    reset_and_check("por");

    script.push_back('{op: int'(OP_ADD), stall: 1, d: 0});
    script.push_back('{op: int'(HALT_C), stall: 1, d: 0});
    run_episode(100, 0, 0, 0, 1'b0);

    script.push_back('{op: int'(OP_MUL), stall: 0, d: MUL_LAT - 1});
    script.push_back('{op: int'(OP_MUL), stall: 2, d: 0});
    script.push_back('{op: int'(OP_MUL), stall: 0, d: 9});
    script.push_back('{op: int'(HALT_C), stall: 0, d: 0});
    run_episode(100, 0, 0, 0, 1'b0);

    script.push_back('{op: int'(OP_SUB), stall: 10, d: 0});
    script.push_back('{op: int'(HALT_C), stall: 10, d: 0});
    run_episode(100, 0, 0, 0, 1'b0);

    script.push_back('{op: 12, stall: 1, d: 0});
    run_episode(100, 0, 0, 0, 1'b0);

    script.push_back('{op: int'(OP_RXOR), stall: 0, d: 0});
    script.push_back('{op: int'(OP_RNOT), stall: 3, d: 0});
    script.push_back('{op: int'(OP_MOVSGPR), stall: 0, d: 0});
    script.push_back('{op: 30, stall: 0, d: 0});
    run_episode(100, 0, 0, 0, 1'b0);

    script.push_back('{op: int'(OP_MUL), stall: 0, d: 30});
    run_episode(100, 0, 0, 0, 1'b1);

    run_episode(300, 0, 0, 15, 1'b0);

    for (int i = 0; i < 4; i++) run_episode(80, 3, 3, 10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
